// File: rtl/pipe_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// The MULDIV_EARLY_OUT_EN build option is implemented in pipe_muldiv_seq.
package pipe_muldiv_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_FIXUP = 2'b10,
        ST_DONE  = 2'b11
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer: shift-add multiply or restoring-divide step.
// In divide mode the low half of acc carries the quotient/dividend shift register.
module muldiv_step
    import pipe_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH:0]     rem,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [WIDTH:0]     rem_next
);

    logic [WIDTH:0] add_sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;

    always_comb begin
        add_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        rem_shift = {rem[WIDTH-1:0], acc[WIDTH-1]};
        // The extra remainder bit holds the borrow of the trial subtraction.
        trial     = rem_shift - {1'b0, operand};
        if (is_div) begin
            acc_next = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ~trial[WIDTH]};
            rem_next = trial[WIDTH] ? rem_shift : trial;
        end else begin
            acc_next = {add_sum, acc[WIDTH-1:1]};
            rem_next = rem;
        end
    end

endmodule

// File: rtl/pipe_muldiv_seq.sv
// EX-stage MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// Define MULDIV_EARLY_OUT_EN to finish multiplies once the multiplier is exhausted.
module pipe_muldiv_seq
    import pipe_muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_e          state_reg;
    logic [CW-1:0]      count_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH:0]     rem_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               is_div_reg;
    logic               sign_q_reg;
    logic               sign_r_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               dbz_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic               op_div;
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH:0]     step_rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        op_div    = (op == MD_DIV) || (op == MD_DIVU);
        op_signed = (op == MD_MULT) || (op == MD_DIV);
        a_neg     = op_signed & opa[WIDTH-1];
        b_neg     = op_signed & opb[WIDTH-1];
        a_mag     = a_neg ? -opa : opa;
        b_mag     = b_neg ? -opb : opb;
        prod_fix  = sign_q_reg ? -acc_reg : acc_reg;
        quot_fix  = sign_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_fix   = sign_r_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
    end

    muldiv_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .is_div  (is_div_reg),
        .acc     (acc_reg),
        .rem     (rem_reg),
        .operand (b_reg),
        .acc_next(step_acc),
        .rem_next(step_rem)
    );

`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0] live_mask;
    logic             early_out;

    // After this step, the multiplier bits still to be consumed are the low count_reg bits.
    always_comb begin
        live_mask = ~({WIDTH{1'b1}} << count_reg);
        early_out = !is_div_reg && ((step_acc[WIDTH-1:0] & live_mask) == '0);
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            acc_reg    <= '0;
            rem_reg    <= '0;
            b_reg      <= '0;
            is_div_reg <= 1'b0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start && !cancel) begin
                        is_div_reg <= op_div;
                        sign_q_reg <= a_neg ^ b_neg;
                        sign_r_reg <= a_neg;
                        count_reg  <= CW'(WIDTH - 1);
                        rem_reg    <= '0;
                        busy_reg   <= 1'b1;
                        if (op_div) begin
                            acc_reg <= {{WIDTH{1'b0}}, a_mag};
                            b_reg   <= b_mag;
                        end else begin
                            acc_reg <= {{WIDTH{1'b0}}, b_mag};
                            b_reg   <= a_mag;
                        end
                        if (op_div && (opb == '0)) begin
                            hi_reg    <= opa;
                            lo_reg    <= '1;
                            dbz_reg   <= 1'b1;
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end
`ifdef MULDIV_EARLY_OUT_EN
                        else if (!op_div && (b_mag == '0)) begin
                            state_reg <= ST_FIXUP;
                        end
`endif
                        else begin
                            state_reg <= ST_CALC;
                        end
                    end
                end

                ST_CALC: begin
                    if (cancel) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        acc_reg <= step_acc;
                        rem_reg <= step_rem;
`ifdef MULDIV_EARLY_OUT_EN
                        if (early_out) begin
                            acc_reg   <= step_acc >> count_reg;
                            state_reg <= ST_FIXUP;
                        end else
`endif
                        if (count_reg == '0) begin
                            state_reg <= ST_FIXUP;
                        end else begin
                            count_reg <= count_reg - CW'(1);
                        end
                    end
                end

                ST_FIXUP: begin
                    if (cancel) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        if (is_div_reg) begin
                            hi_reg  <= rem_fix;
                            lo_reg  <= quot_fix;
                            dbz_reg <= 1'b0;
                        end else begin
                            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_reg <= prod_fix[WIDTH-1:0];
                        end
                        done_reg  <= 1'b1;
                        state_reg <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign stall = ((state_reg == ST_IDLE) && start)
                 || (state_reg == ST_CALC)
                 || (state_reg == ST_FIXUP);
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign dbz   = dbz_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: tb/tb_pipe_muldiv_seq.sv
// Directed bench for pipe_muldiv_seq with a queue of expected HI/LO/dbz/latency results.
// Expected latency follows MULDIV_EARLY_OUT_EN when the bench is built with it.
module tb_pipe_muldiv_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        cancel;
    logic        stall;
    logic        busy;
    logic        done;
    logic        dbz;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          tests;
    int          fails;
    logic        model_dbz;
    logic [31:0] last_hi;
    logic [31:0] last_lo;

    pipe_muldiv_seq #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .opa   (opa),
        .opb   (opb),
        .cancel(cancel),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz),
        .hi    (hi),
        .lo    (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int mul_lat(input logic [31:0] m);
`ifdef MULDIV_EARLY_OUT_EN
        if (m == 32'd0) return 2;
        for (int i = 31; i >= 0; i--) begin
            if (m[i]) return i + 3;
        end
        return 2;
`else
        return (m == 32'd0) ? 34 : 34;
`endif
    endfunction

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic dbz_in);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        e.dbz = dbz_in;
        case (o)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.lat = mul_lat(b[31] ? -b : b);
            end
            2'b01: begin
                p  = 64'(a) * 64'(b);
                e.hi = p[63:32];
                e.lo = p[31:0];
                e.lat = mul_lat(b);
            end
            default: begin
                if (b == 32'd0) begin
                    e.hi  = a;
                    e.lo  = 32'hFFFF_FFFF;
                    e.dbz = 1'b1;
                    e.lat = 1;
                end else begin
                    if (o == 2'b10) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    e.hi  = r[31:0];
                    e.lo  = q[31:0];
                    e.dbz = 1'b0;
                    e.lat = 34;
                end
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        exp_t e;
        int   cyc;
        logic got;
        logic stall_ok;
        e = model(o, a, b, model_dbz);
        sb_q.push_back(e);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        opa   = a;
        opb   = b;
        #1;
        check({tag, " stall_at_start"}, 64'(stall), 64'd1);
        @(posedge clock);
        #1 start = 1'b0;
        cyc      = 0;
        got      = 1'b0;
        stall_ok = 1'b1;
        while (!got && cyc < 100) begin
            @(negedge clock);
            cyc++;
            if (done) got = 1'b1;
            else if (!stall) stall_ok = 1'b0;
        end
        e = sb_q.pop_front();
        check({tag, " done_seen"}, 64'(got), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(e.lat));
        check({tag, " stall_while_busy"}, 64'(stall_ok), 64'd1);
        check({tag, " stall_at_done"}, 64'(stall), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(e.hi));
        check({tag, " lo"}, 64'(lo), 64'(e.lo));
        check({tag, " dbz"}, 64'(dbz), 64'(e.dbz));
        @(negedge clock);
        check({tag, " done_pulse_ends"}, 64'(done), 64'd0);
        $display("[TB] %s op=%0d opa=%h opb=%h -> hi=%h lo=%h dbz=%0d lat=%0d",
                 tag, o, a, b, hi, lo, dbz, cyc);
        model_dbz = e.dbz;
        last_hi   = e.hi;
        last_lo   = e.lo;
    endtask

    initial begin
        int done_cnt;
        tests     = 0;
        fails     = 0;
        model_dbz = 1'b0;
        last_hi   = 32'd0;
        last_lo   = 32'd0;
        reset     = 1'b1;
        start     = 1'b0;
        cancel    = 1'b0;
        op        = 2'b00;
        opa       = 32'd0;
        opb       = 32'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset dbz", 64'(dbz), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset stall", 64'(stall), 64'd0);
        $display("[TB] reset state checked");

        run_op(2'b00, 32'd7, 32'hFFFF_FFFD, "mult_7_m3");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(2'b11, 32'h0000_1234, 32'd0, "divu_by_zero");
        run_op(2'b01, 32'd5, 32'd3, "multu_5_3_keeps_dbz");
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, "div_100_m7_clears_dbz");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minint_sq");
        run_op(2'b01, 32'd5, 32'd0, "multu_zero_mplier");
        run_op(2'b11, 32'hFFFF_FFFF, 32'd1, "divu_by_one");
        for (int i = 0; i < 6; i++) begin
            run_op(2'(i % 4), $urandom, $urandom | 32'd1, $sformatf("rand_%0d", i));
        end

        // start together with cancel in IDLE must be ignored
        @(negedge clock);
        start  = 1'b1;
        cancel = 1'b1;
        op     = 2'b01;
        opa    = 32'd9;
        opb    = 32'd9;
        @(posedge clock);
        #1 start = 1'b0;
        cancel   = 1'b0;
        @(negedge clock);
        check("start_cancel busy", 64'(busy), 64'd0);
        $display("[TB] start+cancel in IDLE ignored busy=%0d", busy);

        // cancel in CALC at cycle 10
        @(negedge clock);
        start = 1'b1;
        op    = 2'b01;
        opa   = 32'h0000_DEAD;
        opb   = 32'hFFFF_FFFF;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (9) @(posedge clock);
        #1 cancel = 1'b1;
        check("cancel busy_at_10", 64'(busy), 64'd1);
        @(posedge clock);
        #1 cancel = 1'b0;
        check("cancel idle_at_11", 64'(busy), 64'd0);
        check("cancel stall_at_11", 64'(stall), 64'd0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) done_cnt++;
        end
        check("cancel no_done", 64'(done_cnt), 64'd0);
        check("cancel hi_kept", 64'(hi), 64'(last_hi));
        check("cancel lo_kept", 64'(lo), 64'(last_lo));
        $display("[TB] cancel at cycle 10 -> busy=%0d hi=%h lo=%h", busy, hi, lo);

        // reset at cycle 5 of a new operation
        @(negedge clock);
        start = 1'b1;
        op    = 2'b11;
        opa   = 32'h1234_5678;
        opb   = 32'h0000_0111;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        check("midop busy_before_reset", 64'(busy), 64'd1);
        @(posedge clock);
        #1 reset = 1'b0;
        check("midop_reset hi", 64'(hi), 64'd0);
        check("midop_reset lo", 64'(lo), 64'd0);
        check("midop_reset busy", 64'(busy), 64'd0);
        check("midop_reset done", 64'(done), 64'd0);
        $display("[TB] reset at cycle 5 -> hi=%h lo=%h busy=%0d", hi, lo, busy);
        model_dbz = 1'b0;
        last_hi   = 32'd0;
        last_lo   = 32'd0;

        run_op(2'b10, 32'hFFFF_FF00, 32'd16, "div_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_muldiv_seq.md
Name: pipe_muldiv_seq

Overview:
- Iterative multiply/divide sequencer that sits beside the EX-stage ALU of the pipelined CPU.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs a 1-bit-per-cycle shift-add or restoring-divide datapath.
- Stalls the pipeline while busy, then updates the architectural HI/LO registers that MFHI/MFLO read.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  EX holds a mul/div instruction; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opa  input  WIDTH  rs value after forwarding.
- opb  input  WIDTH  rt value after forwarding.
- cancel  input  1  pipeline flush; aborts the operation in flight.
- stall  output  1  freeze PC/IF/ID/EX.
- busy  output  1  state is not IDLE.
- done  output  1  one-cycle pulse when HI/LO are updated.
- dbz  output  1  sticky divide-by-zero flag for the last division.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high on `reset`, sampled at the `clock` rising edge.
- Reset values: state=IDLE; hi=0, lo=0, dbz=0, done=0, busy=0. An internal count of 0 is permitted.
- Reset mid-operation: overrides everything, including cancel. It aborts the operation and clears HI/LO.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, start=1: latch operands.
  - For signed ops, latch magnitudes of opa/opb, plus sign_q = a31^b31 and sign_r = a31.
  - Load count = WIDTH-1.
  - Go to CALC.
  - Exception: DIV/DIVU with opb==0 goes straight to DONE with hi=opa, lo={WIDTH{1}}, dbz=1.
- CALC, multiply: each cycle, if multiplier LSB is set, add multiplicand to the upper half of a 2*WIDTH accumulator; then shift right one.
- CALC, divide: each cycle, shift {rem,quot} left one and trial-subtract the divisor. If non-negative, keep the difference and set quot LSB; otherwise restore.
- CALC exit: when count==0, go to FIXUP; otherwise decrement count.
- FIXUP:
  - MULT: negate the 2*WIDTH product if sign_q.
  - DIV: negate the quotient if sign_q, and the remainder if sign_r.
  - Write hi (product high / remainder) and lo (product low / quotient).
  - Clear dbz for a valid division; MULT/MULTU leave dbz unchanged.
  - Go to DONE.
- DONE: done=1 for this cycle only; stall=0. Go to IDLE.
- Latency: start cycle to done pulse is WIDTH+2 cycles (34 at default). The divide-by-zero path takes 1 cycle.
- stall: combinational. stall = (state==IDLE & start) | state==CALC | state==FIXUP.
  - The pipeline holds the instruction in EX until the DONE cycle, then lets it retire.
- start outside IDLE: ignored; no queueing.
- start in the DONE cycle: ignored. The instruction re-presents it in the next IDLE cycle.
- cancel: in CALC or FIXUP, go to IDLE next cycle; hi/lo/dbz unchanged, no done pulse.
  - cancel together with start in IDLE: start is ignored.
  - cancel in DONE: no effect, because the writeback already happened.
- Signed overflow, DIV 0x80000000 / -1: lo=0x80000000, hi=0. No trap.
- Width rules: the accumulator is 2*WIDTH. The divide remainder register is WIDTH+1 bits so the trial-subtract sign bit is kept.

Optional Feature:
- MULDIV_EARLY_OUT_EN defined: in CALC for multiply, when the remaining shifted multiplier is all zero, shift the accumulator right by count+1 in one step and go directly to FIXUP.
  - Latency shrinks to (index of highest set multiplier bit)+3 cycles; a zero multiplier takes 2 cycles.
  - Division is unaffected.
- Undefined: fixed WIDTH+2 latency for every operation.

Decomposition:
- Shared package pipe_muldiv_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state encodings;
  - WIDTH default.
- One natural sub-module: muldiv_step, the combinational single-iteration add/shift and trial-subtract unit. The FSM, counter and sign fix-up stay in the top.

Test Plan:
- MULT opa=7, opb=0xFFFFFFFD -> done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall high for cycles 0..33.
- MULTU opa=opb=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV opa=0xFFFFFFF9 (-7), opb=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, dbz=0.
- DIVU opa=0x1234, opb=0 -> done next cycle; hi=0x1234, lo=0xFFFFFFFF, dbz=1. A following valid DIV clears dbz.
- MULTU in flight; cancel at cycle 10 -> IDLE at cycle 11, no done, hi/lo keep prior values. Then reset at cycle 5 of a new op -> hi=lo=0, busy=0.
- With MULDIV_EARLY_OUT_EN: MULTU opa=5, opb=3 -> done at cycle 4, lo=15. Without it, done at cycle 34.
